servant_mem_arbiter: RTL and testbench

// - Shares the single servant Wishbone memory port between two masters: m0 = SERV CPU, m1 = loader/debug port.
// - Round-robin arbitration with one transaction per grant; a bus watchdog returns err on a missing slave ack.
// - Sits between the CPU/loader buses and the memory; exposes grant/busy status for sim tracing.

---
 rtl/servant_mem_arbiter_pkg.sv | 20 ++
 rtl/servant_mem_arbiter_if.sv | 16 +
 rtl/servant_mem_arbiter_wdog.sv | 34 +++
 rtl/servant_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_servant_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/servant_mem_arbiter_pkg.sv
// Shared types for the servant memory arbiter: FSM states, one-hot grant
// encodings and the watchdog counter width helper.
package servant_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // A disabled watchdog (TIMEOUT=0) still gets a 1-bit counter so widths stay legal.
  function automatic int wdog_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/servant_mem_arbiter_if.sv
// Wishbone-style classic bus used by the servant memory port (cyc doubles as stb).
interface servant_wb_if #(
  parameter int AW = 32
) ();
  logic          cyc;
  logic [AW-1:0] adr;
  logic [31:0]   dat;
  logic [3:0]    sel;
  logic          we;
  logic [31:0]   rdt;
  logic          ack;
  logic          err;

  modport master (output cyc, adr, dat, sel, we, input rdt, ack, err);
  modport slave  (input cyc, adr, dat, sel, we, output rdt, ack, err);
endinterface

// File: rtl/servant_mem_arbiter_wdog.sv
// Bus watchdog: counts granted cycles without a slave ack and flags the
// cycle on which the transaction has to be terminated with err.
module servant_arb_wdog
  import servant_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  input  logic s_ack,
  output logic tc
);

  localparam int WW = wdog_width(TIMEOUT);
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);

  logic [WW-1:0] wdog;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog <= '0;
    end else if (clear) begin
      wdog <= '0;
    end else if (run && !s_ack && (TIMEOUT != 0)) begin
      wdog <= wdog + WW'(1);
    end
  end

  // An ack arriving on the terminal cycle wins, so tc is masked by s_ack.
  assign tc = (TIMEOUT != 0) && run && !s_ack && (wdog == LAST);

endmodule

// File: rtl/servant_mem_arbiter.sv
// Round-robin arbiter sharing the servant memory port between the SERV CPU (m0)
// and the loader/debug port (m1), one transaction per grant, with a bus watchdog.
module servant_mem_arbiter
  import servant_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         wb_clk,
  input  logic         wb_rst_n,
  servant_wb_if.slave  m0,
  servant_wb_if.slave  m1,
  servant_wb_if.master s,
  output logic [1:0]   grant,
  output logic         busy
);

  arb_state_t    state;
  logic          last;
  logic          wdog_tc;
  logic [AW-1:0] adr_mux;

  servant_arb_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (wb_clk),
    .rst_n (wb_rst_n),
    .clear (state == IDLE),
    .run   (state != IDLE),
    .s_ack (s.ack),
    .tc    (wdog_tc)
  );

  // Every grant ends back in IDLE, so the memory always sees a cycle with
  // s_cyc low between owners. An abort (cyc dropped) leaves last untouched.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      grant <= GRANT_NONE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0.cyc && (!m1.cyc || last)) begin
            state <= GNT0;
            grant <= GRANT_M0;
            busy  <= 1'b1;
          end else if (m1.cyc) begin
            state <= GNT1;
            grant <= GRANT_M1;
            busy  <= 1'b1;
          end
        end
        GNT0: begin
          if (!m0.cyc || s.ack || wdog_tc) begin
            state <= IDLE;
            grant <= GRANT_NONE;
            busy  <= 1'b0;
          end
          if (m0.cyc && (s.ack || wdog_tc)) last <= 1'b0;
        end
        GNT1: begin
          if (!m1.cyc || s.ack || wdog_tc) begin
            state <= IDLE;
            grant <= GRANT_NONE;
            busy  <= 1'b0;
          end
          if (m1.cyc && (s.ack || wdog_tc)) last <= 1'b1;
        end
        default: begin
          state <= IDLE;
          grant <= GRANT_NONE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // The non-granted master sees constant zeros; stray acks never reach a master
  // because s_cyc follows the owner's cyc.
  always_comb begin
    s.cyc   = 1'b0;
    adr_mux = '0;
    s.dat   = '0;
    s.sel   = '0;
    s.we    = 1'b0;
    m0.rdt  = '0;
    m0.ack  = 1'b0;
    m0.err  = 1'b0;
    m1.rdt  = '0;
    m1.ack  = 1'b0;
    m1.err  = 1'b0;
    case (state)
      GNT0: begin
        s.cyc   = m0.cyc;
        adr_mux = m0.adr;
        s.dat   = m0.dat;
        s.sel   = m0.sel;
        s.we    = m0.we;
        m0.rdt  = s.rdt;
        m0.ack  = m0.cyc & s.ack;
        m0.err  = m0.cyc & wdog_tc;
      end
      GNT1: begin
        s.cyc   = m1.cyc;
        adr_mux = m1.adr;
        s.dat   = m1.dat;
        s.sel   = m1.sel;
        s.we    = m1.we;
        m1.rdt  = s.rdt;
        m1.ack  = m1.cyc & s.ack;
        m1.err  = m1.cyc & wdog_tc;
      end
      default: ;
    endcase
  end

  assign s.adr = adr_mux;

endmodule

// File: tb/tb_servant_mem_arbiter.sv
// Bench for servant_mem_arbiter: an ownership model checks all outputs on every
// falling edge, while directed scenarios pin the model with literal expectations.
module tb_servant_mem_arbiter;

  localparam int AW      = 32;
  localparam int TIMEOUT = 8;
  localparam logic [1:0] EXP_SEQ [12] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10,
                                          2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

  logic       wb_clk = 1'b0;
  logic       wb_rst_n;
  logic [1:0] grant;
  logic       busy;

  int n_checks  = 0;
  int n_fail    = 0;
  int mem_delay = -1;
  int mem_age   = 0;
  logic mem_waiting;

  int own    = -1;
  int last_w = 1;
  int waited = 0;
  logic        own_cyc;
  logic        tmo;
  logic [1:0]  exp_grant;
  logic [69:0] exp_bus;

  int cyc_cnt;
  int n_cyc;

  servant_wb_if #(.AW(AW)) m0 ();
  servant_wb_if #(.AW(AW)) m1 ();
  servant_wb_if #(.AW(AW)) s ();

  servant_mem_arbiter #(
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .m0       (m0),
    .m1       (m1),
    .s        (s),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 wb_clk = ~wb_clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #2;
  endtask

  task automatic applyStimulus(input int k, input logic cyc, input logic [AW-1:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel, input logic we);
    if (k == 0) begin
      m0.cyc = cyc; m0.adr = adr; m0.dat = dat; m0.sel = sel; m0.we = we;
    end else begin
      m1.cyc = cyc; m1.adr = adr; m1.dat = dat; m1.sel = sel; m1.we = we;
    end
  endtask

  // Bounded wait for a master's ack; cycles counts falling edges including the ack one.
  task automatic waitAck(input int k, input int budget, output int cycles);
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge wb_clk);
      cycles++;
      if ((k == 0) ? m0.ack : m1.ack) return;
    end
    n_checks++;
    n_fail++;
    $display("[TB] FAIL ack_wait_m%0d: no ack within %0d cycles", k, budget);
  endtask

  // Memory: acks mem_delay cycles after s_cyc rises (never when negative).
  initial begin : memory
    s.ack = 1'b0;
    s.rdt = '0;
    s.err = 1'b0;
    forever begin
      @(negedge wb_clk);
      mem_waiting = s.cyc && !s.ack;
      @(posedge wb_clk);
      #1;
      mem_age = (s.cyc && mem_waiting) ? mem_age + 1 : 0;
      s.ack   = s.cyc && (mem_delay >= 0) && (mem_age == mem_delay);
      s.rdt   = mem_data(s.adr);
    end
  end

  // Ownership model: who owns the bus, who was served last, how long the owner has waited.
  initial begin : model
    forever begin
      @(negedge wb_clk);
      if (!wb_rst_n) begin
        own = -1; last_w = 1; waited = 0;
      end
      own_cyc   = (own == 0) ? m0.cyc : (own == 1) ? m1.cyc : 1'b0;
      tmo       = own_cyc && !s.ack && (waited == TIMEOUT - 1);
      exp_grant = (own < 0) ? 2'b00 : 2'(1 << own);
      if (own == 0)      exp_bus = {m0.cyc, m0.we, m0.sel, m0.adr, m0.dat};
      else if (own == 1) exp_bus = {m1.cyc, m1.we, m1.sel, m1.adr, m1.dat};
      else               exp_bus = '0;
      checkOutput("status", {grant, busy}, {exp_grant, own >= 0});
      checkOutput("slave_bus", {s.cyc, s.we, s.sel, s.adr, s.dat}, exp_bus);
      checkOutput("m0_resp", {m0.ack, m0.err, m0.rdt},
                  (own == 0) ? {own_cyc && s.ack, tmo, s.rdt} : 34'h0);
      checkOutput("m1_resp", {m1.ack, m1.err, m1.rdt},
                  (own == 1) ? {own_cyc && s.ack, tmo, s.rdt} : 34'h0);
      if (wb_rst_n) begin
        if (own < 0) begin
          waited = 0;
          if (m0.cyc && m1.cyc) own = 1 - last_w;
          else if (m0.cyc)      own = 0;
          else if (m1.cyc)      own = 1;
        end else if (!own_cyc) begin
          own = -1;
        end else if (s.ack || tmo) begin
          last_w = own;
          own    = -1;
        end else begin
          waited++;
        end
      end
    end
  end

  initial begin : stimulus
    wb_rst_n = 1'b0;
    applyStimulus(0, 1'b0, '0, '0, 4'h0, 1'b0);
    applyStimulus(1, 1'b0, '0, '0, 4'h0, 1'b0);
    mem_delay = 1;
    repeat (2) @(negedge wb_clk);
    checkOutput("reset_outputs", {grant, busy, s.cyc, m0.ack, m0.err, m1.ack, m1.err}, 7'b0);
    tick();
    wb_rst_n = 1'b1;

    // Single CPU read, memory acks one cycle after s_cyc
    tick();
    applyStimulus(0, 1'b1, 32'h100, '0, 4'hF, 1'b0);
    @(negedge wb_clk);
    checkOutput("t1_latency", {grant, s.cyc}, 3'b000);
    @(negedge wb_clk);
    checkOutput("t1_grant", {grant, s.cyc, s.adr}, {2'b01, 1'b1, 32'h100});
    checkOutput("t1_no_ack_yet", m0.ack, 1'b0);
    @(negedge wb_clk);
    checkOutput("t1_ack", {m0.ack, m0.rdt}, {1'b1, 32'hC0DE_0100});
    tick();
    applyStimulus(0, 1'b0, '0, '0, 4'h0, 1'b0);
    @(negedge wb_clk);
    checkOutput("t1_idle", {grant, busy, m0.ack}, 4'b0);

    // Both masters hold requests: grants alternate with an IDLE cycle between
    tick();
    mem_delay = 0;
    applyStimulus(0, 1'b1, 32'h10, '0, 4'hF, 1'b0);
    applyStimulus(1, 1'b1, 32'h20, '0, 4'hF, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge wb_clk);
      checkOutput($sformatf("t2_grant%0d", i), grant, EXP_SEQ[i]);
    end
    tick();
    applyStimulus(0, 1'b0, '0, '0, 4'h0, 1'b0);
    applyStimulus(1, 1'b0, '0, '0, 4'h0, 1'b0);

    // Loader write goes through unchanged; CPU side stays quiet
    tick();
    mem_delay = 2;
    applyStimulus(1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF, 1'b1);
    @(negedge wb_clk);
    @(negedge wb_clk);
    checkOutput("t3_bus", {s.cyc, s.we, s.sel, s.adr, s.dat},
                {1'b1, 1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF});
    checkOutput("t3_m0_quiet", {m0.ack, m0.err, m0.rdt}, 34'h0);
    waitAck(1, 10, n_cyc);
    checkOutput("t3_ack_latency", n_cyc, 2);
    tick();
    applyStimulus(1, 1'b0, '0, '0, 4'h0, 1'b0);

    // Slave never acks: m0 errs on its 8th granted cycle, then pending m1 wins
    tick();
    mem_delay = -1;
    applyStimulus(0, 1'b1, 32'h300, '0, 4'hF, 1'b0);
    applyStimulus(1, 1'b1, 32'h400, '0, 4'hF, 1'b0);
    cyc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk);
      if (grant == 2'b01) cyc_cnt++;
      if (m0.err) break;
    end
    checkOutput("t4_err_cycles", cyc_cnt, 8);
    checkOutput("t4_err_pulse", {m0.err, m0.ack}, 2'b10);
    tick();
    mem_delay = 1;
    @(negedge wb_clk);
    checkOutput("t4_release", {s.cyc, grant}, 3'b000);
    @(negedge wb_clk);
    checkOutput("t4_m1_granted", grant, 2'b10);
    waitAck(1, 10, n_cyc);
    checkOutput("t4_m1_ack_latency", n_cyc, 1);
    tick();
    applyStimulus(0, 1'b0, '0, '0, 4'h0, 1'b0);
    applyStimulus(1, 1'b0, '0, '0, 4'h0, 1'b0);

    // Ack on the watchdog terminal cycle is forwarded without err
    tick();
    mem_delay = TIMEOUT - 1;
    applyStimulus(1, 1'b1, 32'h500, '0, 4'hF, 1'b0);
    waitAck(1, 20, n_cyc);
    checkOutput("t5_ack_cycle", n_cyc, 9);
    checkOutput("t5_no_err", m1.err, 1'b0);
    tick();
    applyStimulus(1, 1'b0, '0, '0, 4'h0, 1'b0);

    // CPU aborts mid-grant: back to IDLE, last stays m1 so m0 wins the next tie
    tick();
    mem_delay = -1;
    applyStimulus(0, 1'b1, 32'h600, '0, 4'hF, 1'b0);
    repeat (3) @(negedge wb_clk);
    tick();
    applyStimulus(0, 1'b0, '0, '0, 4'h0, 1'b0);
    @(negedge wb_clk);
    checkOutput("t5_abort", {grant, s.cyc, m0.err, m0.ack}, 5'b01000);
    tick();
    mem_delay = 0;
    applyStimulus(0, 1'b1, 32'h700, '0, 4'hF, 1'b0);
    applyStimulus(1, 1'b1, 32'h800, '0, 4'hF, 1'b0);
    @(negedge wb_clk);
    @(negedge wb_clk);
    checkOutput("t5_last_kept", grant, 2'b01);
    tick();
    applyStimulus(0, 1'b0, '0, '0, 4'h0, 1'b0);
    applyStimulus(1, 1'b0, '0, '0, 4'h0, 1'b0);

    // Asynchronous reset in the middle of an m1 grant
    tick();
    mem_delay = -1;
    applyStimulus(1, 1'b1, 32'h900, '0, 4'hF, 1'b0);
    @(negedge wb_clk);
    @(negedge wb_clk);
    checkOutput("t6_gnt1", grant, 2'b10);
    @(posedge wb_clk);
    #3;
    wb_rst_n = 1'b0;
    #1;
    checkOutput("t6_async_reset", {s.cyc, grant, busy}, 4'b0);
    mem_delay = 0;
    applyStimulus(0, 1'b1, 32'hA00, '0, 4'hF, 1'b0);
    applyStimulus(1, 1'b1, 32'hB00, '0, 4'hF, 1'b0);
    tick();
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    @(negedge wb_clk);
    checkOutput("t6_tie_after_reset", grant, 2'b01);
    tick();
    applyStimulus(0, 1'b0, '0, '0, 4'h0, 1'b0);
    applyStimulus(1, 1'b0, '0, '0, 4'h0, 1'b0);
    repeat (2) @(negedge wb_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
